// File: rtl/serial_arith_unit.sv
// serial_arith_unit: bit-serial arithmetic unit.
// One full-adder slice plus a carry flop evaluates A + Y + Cin one bit per
// clock, LSB first, where Y is chosen per bit by s1/s0 (0, B, ~B or all-ones).
//
// Handshake: a controller raises start while the unit is in IDLE or DONE; the
// operands are captured on that edge. busy is high while bits are being
// processed. done is a one-cycle pulse marking F/Cout valid. F/Cout then hold
// until the next operation completes.
module serial_arith_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             s1,
  input  logic             s0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             s1_q, s1_d;
  logic             s0_q, s0_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             cout_q, cout_d;

  logic accept;
  logic last_bit;
  logic a_bit, b_bit, y_bit, f_bit, c_next;

  // Single full-adder slice working on the bit selected by the counter.
  always_comb begin
    a_bit  = a_q[cnt_q];
    b_bit  = b_q[cnt_q];
    y_bit  = (b_bit & s0_q) | (~b_bit & s1_q);
    f_bit  = a_bit ^ y_bit ^ c_q;
    c_next = (a_bit & y_bit) | (a_bit & c_q) | (y_bit & c_q);
  end

  // Control FSM: decides when a start is accepted and when the last bit runs.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // start is deliberately ignored here; operands stay as captured.
        if (cnt_q == LAST_IDX) begin
          last_bit = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        // Back-to-back start is taken exactly as from IDLE.
        if (start) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: operand capture, serial shifting and result load.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    s1_d   = s1_q;
    s0_d   = s0_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    f_d    = f_q;
    cout_d = cout_q;
    if (accept) begin
      a_d   = A;
      b_d   = B;
      s1_d  = s1;
      s0_d  = s0;
      c_d   = Cin;
      cnt_d = '0;
      res_d = '0;
    end else if (state_q == ST_SHIFT) begin
      // Result shifts right so bit 0 ends up in the LSB after WIDTH steps.
      res_d = {f_bit, res_q[WIDTH-1:1]};
      c_d   = c_next;
      if (last_bit) begin
        // Counter holds on the final bit instead of wrapping.
        f_d    = {f_bit, res_q[WIDTH-1:1]};
        cout_d = c_next;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State and datapath registers; async reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s1_q    <= 1'b0;
      s0_q    <= 1'b0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s1_q    <= s1_d;
      s0_q    <= s0_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
    end
  end

  assign busy        = (state_q == ST_SHIFT);
  assign done        = (state_q == ST_DONE);
  assign F           = f_q;
  assign Cout        = cout_q;
  assign dbg_state_o = state_q;

endmodule
